// File: rtl/keypad_pkg_sj.sv
// Shared types, keymap and helper functions for the 4x4 keypad scanner.
package keypad_pkg_sj;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Indexed [row][col]; row r is the one driven low, col c the one read low.
    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [3:0] next_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

    // Index of the lowest-numbered low bit; also decodes the one-cold row vector.
    function automatic logic [1:0] low_col(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scanner_sj_sync.sv
// Two-flop synchronizer, resets to all-ones (idle level of pulled-up columns).
module sync_2ff_sj #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner_sj.sv
// 4x4 keypad row scanner with press/release debounce and two-digit key history.
module keypad_scanner_sj
    import keypad_pkg_sj::*;
#(
    parameter int unsigned SCAN_DIV        = 4096,
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] s_new,
    output logic [3:0] s_old
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    cols_s;
    state_e        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] db_q, db_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    rows_d, code_d, new_d, old_d;
    logic          kv_d;
    logic          col_high;

    sync_2ff_sj #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cols),
        .q     (cols_s)
    );

    assign col_high = cols_s[col_q];

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            dwell_q   <= '0;
            db_q      <= '0;
            col_q     <= '0;
            rows      <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= '0;
            s_new     <= '0;
            s_old     <= '0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            db_q      <= db_d;
            col_q     <= col_d;
            rows      <= rows_d;
            key_valid <= kv_d;
            key_code  <= code_d;
            s_new     <= new_d;
            s_old     <= old_d;
        end
    end

    // Next-state and output logic; the latched row is frozen outside SCAN.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        db_d    = db_q;
        col_d   = col_q;
        rows_d  = rows;
        kv_d    = 1'b0;
        code_d  = key_code;
        new_d   = s_new;
        old_d   = s_old;
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (cols_s != 4'hF) begin
                        col_d   = low_col(cols_s);
                        db_d    = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        rows_d = next_row(rows);
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (col_high) begin
                    state_d = SCAN;
                    rows_d  = next_row(rows);
                    dwell_d = '0;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = HELD;
                    db_d    = '0;
                    kv_d    = 1'b1;
                    code_d  = KEYMAP[low_col(rows)][col_q];
                    old_d   = s_new;
                    new_d   = KEYMAP[low_col(rows)][col_q];
                end else begin
                    db_d = db_q + BW'(1);
                end
            end
            HELD: begin
                if (col_high) begin
                    state_d = RELEASE;
                    db_d    = '0;
                end
            end
            RELEASE: begin
                if (!col_high) begin
                    db_d = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = SCAN;
                    db_d    = '0;
                    dwell_d = '0;
                    rows_d  = next_row(rows);
                end else begin
                    db_d = db_q + BW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

endmodule
